// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-and-add multiplier that borrows the datapath ALU adder
// One partial-product add is issued per RUN cycle and the ALU sum is written back to acc.
module alu_mul_seq #(
   parameter int         WIDTH   = 32,
   parameter logic [3:0] ADD_SEL = 4'b0010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [4:0]       cnt;
   logic             last_iter;
   logic             unused_alu_zero;

   assign alu_a   = acc;
   assign alu_b   = mplr[0] ? mcand : '0;
   assign alu_sel = ADD_SEL;

   // Stop as soon as no multiplier bits remain above the one being added now.
   assign last_iter = ((mplr >> 1) == '0) || (cnt == 5'(WIDTH - 1));

   assign unused_alu_zero = alu_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b1;
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  acc   <= '0;
                  mcand <= op_a;
                  mplr  <= op_b;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               acc   <= alu_out;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 5'd1;
               if (last_iter) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= alu_out;
                  zero   <= (alu_out == '0);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign alu_out  = (alu_sel == 4'b0010) ? alu_a + alu_b : '0;
   assign alu_zero = (alu_out == '0);

   alu_mul_seq #(.WIDTH(WIDTH), .ADD_SEL(4'b0010)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .zero(zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zero(alu_zero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      int          k;
   } vec_t;

   function automatic int ref_k(input logic [31:0] b);
      int k = 1;
      for (int i = 0; i < 32; i++)
         if (b[i]) k = i + 1;
      return k;
   endfunction

   function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at the sample point of cycle 0; returns at cycle 1 of the job.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      tick();
      start = 1'b0;
   endtask

   // Called at the first busy cycle; returns at the cycle after done.
   task automatic finish_job(input string name, input logic [31:0] exp, input int expk);
      int nb = 0;
      while (busy === 1'b1 && nb < 40) begin
         if (nb == 0) check({name, " acc_clear"}, alu_a, 32'h0);
         check({name, " alu_sel"}, {28'b0, alu_sel}, 32'h2);
         check({name, " no_early_done"}, {31'b0, done}, 32'h0);
         nb++;
         tick();
      end
      check({name, " busy_cycles"}, nb, expk);
      check({name, " done"}, {31'b0, done}, 32'h1);
      check({name, " result"}, result, exp);
      check({name, " zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
      tick();
      check({name, " done_pulse"}, {31'b0, done}, 32'h0);
      check({name, " result_hold"}, result, exp);
   endtask

   vec_t tbl[5];

   initial begin
      int pulses;
      logic [31:0] a, b;
      int sh;

      tbl[0] = '{32'd6,        32'd7,        32'd42,       3};
      tbl[1] = '{32'h12345678, 32'h0,        32'h0,        1};
      tbl[2] = '{32'h12345678, 32'h1,        32'h12345678, 1};
      tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32};
      tbl[4] = '{32'h80000000, 32'h2,        32'h0,        2};

      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
      tick(); tick();
      check("rst busy", {31'b0, busy}, 32'h0);
      check("rst done", {31'b0, done}, 32'h0);
      check("rst result", result, 32'h0);
      check("rst zero", {31'b0, zero}, 32'h1);
      check("rst alu_a", alu_a, 32'h0);
      check("rst alu_b", alu_b, 32'h0);
      check("rst alu_sel", {28'b0, alu_sel}, 32'h2);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         issue(tbl[i].a, tbl[i].b);
         finish_job($sformatf("tbl%0d", i), tbl[i].prod, tbl[i].k);
      end

      for (int i = 0; i < 30; i++) begin
         a  = $urandom;
         sh = $urandom_range(0, 31);
         b  = $urandom >> sh;
         if ($urandom_range(0, 7) == 0) b = 32'h0;
         issue(a, b);
         finish_job($sformatf("rnd%0d", i), ref_prod(a, b), ref_k(b));
      end

      // start during RUN is dropped; start in DONE is taken
      issue(32'd5, 32'd3);
      check("ign busy1", {31'b0, busy}, 32'h1);
      start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      tick();
      start = 1'b0;
      check("ign busy2", {31'b0, busy}, 32'h1);
      tick();
      check("ign done", {31'b0, done}, 32'h1);
      check("ign result", result, 32'd15);
      issue(32'd9, 32'd9);
      check("b2b busy", {31'b0, busy}, 32'h1);
      check("b2b old_result", result, 32'd15);
      finish_job("b2b", 32'd81, 4);

      // reset in RUN cycle 10 of a 32-iteration job
      issue(32'hFFFFFFFF, 32'h80000000);
      repeat (9) tick();
      check("mid busy_c10", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid busy", {31'b0, busy}, 32'h0);
      check("mid done", {31'b0, done}, 32'h0);
      check("mid result", result, 32'h0);
      check("mid zero", {31'b0, zero}, 32'h1);
      check("mid alu_a", alu_a, 32'h0);
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1 || busy === 1'b1) pulses++;
         tick();
      end
      check("mid no_activity", pulses, 0);

      // rst and start together: rst wins
      rst = 1'b1; start = 1'b1; op_a = 32'd3; op_b = 32'd3;
      tick();
      rst = 1'b0; start = 1'b0;
      tick();
      check("rst_start busy", {31'b0, busy}, 32'h0);
      check("rst_start done", {31'b0, done}, 32'h0);

      issue(32'd6, 32'd7);
      finish_job("post_rst", 32'd42, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
